// File: rtl/nv_arb_pkg.sv
// Shared types and helpers for the NVDLA grant schedulers.
// Holds the arbiter FSM encoding and the weight normalisation.
package nv_arb_pkg;

   localparam int NV_ARB_MAXREQ = 16;
   localparam int NV_ARB_WMAX = 16;

   typedef enum logic {
      IDLE,
      ACTIVE
   } arb_st_e;

   function automatic logic [NV_ARB_WMAX-1:0] wt_eff(
      input logic [NV_ARB_WMAX-1:0] w
   );
      return (w == '0) ? NV_ARB_WMAX'(1) : w;
   endfunction

endpackage

// File: rtl/nv_rr_pick.sv
// Circular priority picker: first set req bit after cur,
// wrapping, with cur itself as the last candidate.
module nv_rr_pick
   import nv_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] cur,
   output logic             found,
   output logic [NREQ-1:0]  oh,
   output logic [IDX_W-1:0] idx
);

   int               j;
   logic [IDX_W-1:0] jj;

   // Walk from the farthest candidate inward so the nearest wins.
   always_comb begin
      found = 1'b0;
      oh    = '0;
      idx   = '0;
      j     = 0;
      jj    = '0;
      for (int i = NREQ; i >= 1; i--) begin
         j = int'(cur) + i;
         if (j >= NREQ) j = j - NREQ;
         jj = IDX_W'(j);
         if (req[jj]) begin
            found  = 1'b1;
            oh     = '0;
            oh[jj] = 1'b1;
            idx    = jj;
         end
      end
   end

endmodule

// File: rtl/nv_wrr_arb.sv
// Weighted round-robin grant scheduler with registered one-hot
// grant and valid/ready handshake toward the shared resource.
module nv_wrr_arb
   import nv_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int WT_W = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic                 nvdla_core_clk,
   input  logic                 nvdla_core_rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*WT_W-1:0] wt,
   input  logic                 gnt_rdy,
   output logic                 gnt_vld,
   output logic [NREQ-1:0]      gnt,
   output logic [IDX_W-1:0]     gnt_idx
);

   localparam logic [IDX_W-1:0] CUR_RST = IDX_W'(NREQ - 1);

   arb_st_e          st;
   arb_st_e          st_nxt;
   logic [IDX_W-1:0] cur;
   logic [IDX_W-1:0] cur_nxt;
   logic [IDX_W-1:0] idx_nxt;
   logic [IDX_W-1:0] pk_idx;
   logic [WT_W-1:0]  cnt;
   logic [WT_W-1:0]  cnt_nxt;
   logic [WT_W-1:0]  wt_sel;
   logic [WT_W-1:0]  cnt_ld;
   logic [NREQ-1:0]  gnt_nxt;
   logic [NREQ-1:0]  pk_oh;
   logic             pk_found;
   logic             ld;
   logic             cont;

   nv_rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (req),
      .cur   (cur),
      .found (pk_found),
      .oh    (pk_oh),
      .idx   (pk_idx)
   );

   assign gnt_vld = (st == ACTIVE);
   assign ld      = !gnt_vld || gnt_rdy;
   assign cont    = req[cur] && (cnt != '0);
   assign wt_sel  = wt[pk_idx*WT_W +: WT_W];
   assign cnt_ld  = WT_W'(wt_eff(NV_ARB_WMAX'(wt_sel))
                         - NV_ARB_WMAX'(1));

   always_comb begin
      st_nxt  = st;
      cur_nxt = cur;
      cnt_nxt = cnt;
      gnt_nxt = gnt;
      idx_nxt = gnt_idx;
      if (ld) begin
         if (cont) begin
            st_nxt  = ACTIVE;
            cnt_nxt = cnt - 1'b1;
            gnt_nxt = NREQ'(1) << cur;
            idx_nxt = cur;
         end else if (pk_found) begin
            st_nxt  = ACTIVE;
            cur_nxt = pk_idx;
            cnt_nxt = cnt_ld;
            gnt_nxt = pk_oh;
            idx_nxt = pk_idx;
         end else begin
            st_nxt  = IDLE;
            cnt_nxt = '0;
            gnt_nxt = '0;
            idx_nxt = '0;
         end
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         st      <= IDLE;
         cur     <= CUR_RST;
         cnt     <= '0;
         gnt     <= '0;
         gnt_idx <= '0;
      end else begin
         st      <= st_nxt;
         cur     <= cur_nxt;
         cnt     <= cnt_nxt;
         gnt     <= gnt_nxt;
         gnt_idx <= idx_nxt;
      end
   end

endmodule

// File: tb/tb_nv_wrr_arb.sv
// Directed bench for nv_wrr_arb: vector table plus hand
// sequences for early drop, reset mid-burst and max weight.
module tb_nv_wrr_arb;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] wt;
   logic        rdy;
   logic        vld;
   logic [3:0]  gnt;
   logic [1:0]  idx;

   int n_tests;
   int n_fail;

   typedef struct {
      string       name;
      logic        rst;
      logic [3:0]  req;
      logic [15:0] wt;
      logic        rdy;
      logic        vld;
      logic [3:0]  gnt;
      logic [1:0]  idx;
   } vec_t;

   vec_t vq[$];

   nv_wrr_arb #(
      .NREQ (4),
      .WT_W (4)
   ) dut (
      .nvdla_core_clk (clk),
      .nvdla_core_rst (rst),
      .req            (req),
      .wt             (wt),
      .gnt_rdy        (rdy),
      .gnt_vld        (vld),
      .gnt            (gnt),
      .gnt_idx        (idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add(
      input string n, input logic r, input logic [3:0] q,
      input logic [15:0] w, input logic y,
      input logic v, input logic [3:0] g, input logic [1:0] x
   );
      vec_t e;
      e.name = n; e.rst = r; e.req = q; e.wt = w; e.rdy = y;
      e.vld = v; e.gnt = g; e.idx = x;
      vq.push_back(e);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(
      input logic r, input logic [3:0] q,
      input logic [15:0] w, input logic y
   );
      rst = r; req = q; wt = w; rdy = y;
   endtask

   task automatic chk(
      input string n, input logic v,
      input logic [3:0] g, input logic [1:0] x
   );
      n_tests++;
      if (vld !== v || gnt !== g || idx !== x) begin
         n_fail++;
         $display("FAIL %s: got vld=%b gnt=%b idx=%0d, want vld=%b gnt=%b idx=%0d",
                  n, vld, gnt, idx, v, g, x);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      drive(1'b1, 4'b1111, 16'h1111, 1'b1);

      add("rst0", 1, 4'hF, 16'h1111, 1, 0, 4'b0000, 0);
      add("rst1", 1, 4'hF, 16'h1111, 1, 0, 4'b0000, 0);
      add("rst2", 1, 4'hF, 16'h1111, 1, 0, 4'b0000, 0);
      add("first", 0, 4'hF, 16'h1111, 1, 1, 4'b0001, 0);
      add("eq1", 0, 4'hF, 16'h1111, 1, 1, 4'b0010, 1);
      add("eq2", 0, 4'hF, 16'h1111, 1, 1, 4'b0100, 2);
      add("eq3", 0, 4'hF, 16'h1111, 1, 1, 4'b1000, 3);
      add("eq0", 0, 4'hF, 16'h1111, 1, 1, 4'b0001, 0);
      add("eq1b", 0, 4'hF, 16'h1111, 1, 1, 4'b0010, 1);
      add("wrst", 1, 4'hF, 16'h0123, 1, 0, 4'b0000, 0);
      add("w0a", 0, 4'hF, 16'h0123, 1, 1, 4'b0001, 0);
      add("w0b", 0, 4'hF, 16'h0123, 1, 1, 4'b0001, 0);
      add("w0c", 0, 4'hF, 16'h0123, 1, 1, 4'b0001, 0);
      add("w1a", 0, 4'hF, 16'h0123, 1, 1, 4'b0010, 1);
      add("w1b", 0, 4'hF, 16'h0123, 1, 1, 4'b0010, 1);
      add("w2", 0, 4'hF, 16'h0123, 1, 1, 4'b0100, 2);
      add("w3", 0, 4'hF, 16'h0123, 1, 1, 4'b1000, 3);
      add("w0d", 0, 4'hF, 16'h0123, 1, 1, 4'b0001, 0);
      add("w0e", 0, 4'hF, 16'h0123, 1, 1, 4'b0001, 0);
      add("w0f", 0, 4'hF, 16'h0123, 1, 1, 4'b0001, 0);
      add("bp_in", 0, 4'hF, 16'h0123, 1, 1, 4'b0010, 1);
      for (int i = 0; i < 5; i++)
         add($sformatf("bp_hold%0d", i), 0, 4'b1101, 16'h0123, 0,
             1, 4'b0010, 1);
      add("bp_rel", 0, 4'b1101, 16'h0123, 1, 1, 4'b0100, 2);
      add("bp_w3", 0, 4'b1101, 16'h0123, 1, 1, 4'b1000, 3);
      add("bp_w0", 0, 4'b1101, 16'h0123, 1, 1, 4'b0001, 0);
      add("idle", 0, 4'b0000, 16'h0123, 1, 0, 4'b0000, 0);

      foreach (vq[k]) begin
         drive(vq[k].rst, vq[k].req, vq[k].wt, vq[k].rdy);
         tick();
         chk(vq[k].name, vq[k].vld, vq[k].gnt, vq[k].idx);
      end

      // Early drop of req[0] forfeits the burst; return is fresh.
      drive(1'b1, 4'b0101, 16'h0004, 1'b1);
      tick();
      chk("ed_rst", 0, 4'b0000, 0);
      rst = 1'b0;
      tick(); chk("ed_g1", 1, 4'b0001, 0);
      tick(); chk("ed_g2", 1, 4'b0001, 0);
      req = 4'b0100;
      tick(); chk("ed_drop", 1, 4'b0100, 2);
      req = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("ed_fresh%0d", i), 1, 4'b0001, 0);
      end
      tick(); chk("ed_back2", 1, 4'b0100, 2);

      // Reset in the middle of a weight-3 burst on requester 1.
      drive(1'b1, 4'b0010, 16'h0030, 1'b1);
      tick();
      rst = 1'b0;
      tick(); chk("rm_g1", 1, 4'b0010, 1);
      rst = 1'b1;
      tick(); chk("rm_rst", 0, 4'b0000, 0);
      drive(1'b0, 4'b0110, 16'h0030, 1'b1);
      tick(); chk("rm_r0", 1, 4'b0010, 1);
      tick(); chk("rm_r1", 1, 4'b0010, 1);
      tick(); chk("rm_r2", 1, 4'b0010, 1);
      tick(); chk("rm_next", 1, 4'b0100, 2);

      // Maximum weight gives 15 grants with no counter wrap.
      drive(1'b1, 4'b0011, 16'h000F, 1'b1);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         chk($sformatf("mx%0d", i), 1, 4'b0001, 0);
      end
      tick(); chk("mx_end", 1, 4'b0010, 1);

      // Idle, then a new request appears only after the edge.
      req = 4'b0000;
      tick(); chk("id_idle", 0, 4'b0000, 0);
      req = 4'b1000;
      #1; chk("id_nocomb", 0, 4'b0000, 0);
      tick(); chk("id_wake", 1, 4'b1000, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
